mul_seq: RTL
============

# mul_seq

Sequential radix-2 shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU group. It performs the inverse operation of the pipelined non-restoring divider and sits beside it in the execute stage's M-extension path. Operands enter through a valid/ready handshake, and the product is produced iteratively, one multiplier bit per clock. The selected 32-bit half is returned through a second valid/ready handshake.

## Interface
- DATA_WIDTH, 32, operand and result width; product is 2*DATA_WIDTH internally
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands and op valid
- in_ready  output  1  block idle, can accept; reset 1
- op  input  2  00 MUL (low, signless), 01 MULH (s×s high), 10 MULHSU (s×u high), 11 MULHU (u×u high)
- multiplicand  input  DATA_WIDTH  rs1 value
- multiplier  input  DATA_WIDTH  rs2 value
- out_valid  output  1  result valid; reset 0
- out_ready  input  1  consumer accepts result
- result  output  DATA_WIDTH  selected product half; reset 0
- busy  output  1  state != IDLE; reset 0

## Operation
- FSM states: IDLE, CALC, SIGN, DONE. Reset puts the FSM in IDLE.
- IDLE: in_ready=1. On in_valid&in_ready:
  - latch op;
  - compute operand signs: rs1 is signed for MULH/MULHSU, rs2 is signed for MULH only;
  - latch absolute values: mcand zero-extended to 2*DATA_WIDTH, mplier DATA_WIDTH bits;
  - neg = sign1 XOR sign2; clear acc (2*DATA_WIDTH) and cnt;
  - go to CALC.
- CALC, each edge:
  - if mplier[0], acc += mcand;
  - mcand <<= 1, mplier >>= 1, cnt++;
  - on the edge where cnt reaches DATA_WIDTH-1, go to SIGN.
- SIGN, one edge:
  - acc = neg ? -acc : acc (2*DATA_WIDTH two's complement);
  - result = op==MUL ? acc[DATA_WIDTH-1:0] : acc[2*DATA_WIDTH-1:DATA_WIDTH];
  - go to DONE.
- DONE: out_valid=1, result held stable. On out_ready, go to IDLE and drop out_valid on the same edge.
- Width rules:
  - abs(-2^(DATA_WIDTH-1)) = 2^(DATA_WIDTH-1), held unsigned in DATA_WIDTH bits, so there is no overflow.
  - acc never exceeds (2^DATA_WIDTH-1)^2, so it never wraps.
- MUL low half is the same for any signedness; op 00 treats both operands unsigned.
- Only one operation is in flight. in_ready=0 in CALC/SIGN/DONE, and in_valid is ignored there.
- Reset mid-operation (any state): on the next edge the FSM goes to IDLE with in_ready=1, out_valid=0, result=0, busy=0, and the operation is discarded.

## Timing
- Accept edge E0. CALC spans DATA_WIDTH edges (E1..E32 for 32); SIGN at E33.
- out_valid is high starting from the edge after the SIGN edge. The latency from E0 to out_valid is DATA_WIDTH+1 edges (33 at default).
- The result handshake completes on the edge with out_valid&out_ready. in_ready=1 from the next cycle, so back-to-back issue costs one idle cycle.
- out_ready held high: out_valid is high for exactly one cycle.

## Configuration
- MUL_EARLY_OUT_EN defined:
  - CALC also exits to SIGN on any edge where the post-shift mplier==0, with a minimum of one CALC edge;
  - latency = (index of highest set bit of |rs2|)+2 edges; rs2==0 gives latency 2.
- Undefined: fixed latency DATA_WIDTH+1 for all operands. Results are identical either way.

## Structure
- Shared package mul_pkg holds:
  - op encodings OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU;
  - FSM state encoding;
  - DATA_WIDTH default, also used by the divider wrapper.
- One sub-module, mul_sign_fix (combinational):
  - takes acc, neg and op, and returns the corrected, half-selected result;
  - is reused on the operand side as conditional two's-complement abs.

## Test plan
- MUL 7×6, out_ready=1:
  - result=42 (0x0000002A), out_valid exactly 33 edges after accept, high for one cycle;
  - with MUL_EARLY_OUT_EN: latency 4.
- 0xFFFFFFFF×0xFFFFFFFF across ops: MUL→0x00000001, MULH→0x00000000, MULHSU→0xFFFFFFFF, MULHU→0xFFFFFFFE.
- MULH 0x80000000×0xFFFFFFFF:
  - result 0x00000000; MUL same operands → 0x80000000;
  - MULHSU 0x80000000×0x00000002 → 0xFFFFFFFF.
- Backpressure, operation complete, out_ready=0 for 5 cycles:
  - result and out_valid stable, in_ready=0, in_valid pulses ignored;
  - after the out_ready handshake, in_ready=1 next cycle, and a new MULHU 0x10000×0x10000 returns 0x00000001.
- rst_n=0 for one edge at CALC cycle 10:
  - next cycle in_ready=1, out_valid=0, busy=0, result=0;
  - a following MUL 3×5 returns 15 with full latency.
- rs2=0 with MUL_EARLY_OUT_EN: result 0, latency 2 edges. Without the macro: latency 33.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared M-extension definitions: default operand width, multiply op encodings,
// multiplier FSM states and operand-signedness helpers.
package mul_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_SIGN = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    function automatic logic rs1_signed(input op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU);
    endfunction

    function automatic logic rs2_signed(input op_e op);
        return (op == OP_MULH);
    endfunction

endpackage

// File: rtl/mul_sign_fix.sv
// Conditional two's-complement of a double-width value followed by half selection.
// Combinational; also serves as operand abs() when fed a zero-extended operand with OP_MUL.
module mul_sign_fix
    import mul_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [2*DATA_WIDTH-1:0] i_acc,
    input  logic                    i_neg,
    input  op_e                     i_op,
    output logic [DATA_WIDTH-1:0]   o_result
);

    logic [2*DATA_WIDTH-1:0] w_fixed;

    assign w_fixed  = i_neg ? -i_acc : i_acc;
    assign o_result = (i_op == OP_MUL) ? w_fixed[DATA_WIDTH-1:0]
                                       : w_fixed[2*DATA_WIDTH-1:DATA_WIDTH];

endmodule

// File: rtl/mul_seq.sv
// Radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU, one op in flight, result held until o_out_ready.
// Latency DATA_WIDTH+1 edges; with MUL_EARLY_OUT_EN defined CALC stops once the remaining multiplier is zero.
module mul_seq
    import mul_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [1:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_multiplicand,
    input  logic [DATA_WIDTH-1:0] i_multiplier,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_busy
);

    localparam int CW = $clog2(DATA_WIDTH);

    state_e                  r_state;
    state_e                  w_state_nxt;
    op_e                     r_op;
    logic [2*DATA_WIDTH-1:0] r_mcand;
    logic [2*DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0]   r_mplier;
    logic [DATA_WIDTH-1:0]   r_result;
    logic [CW-1:0]           r_cnt;
    logic                    r_neg;

    op_e                     w_op_in;
    logic                    w_sign1;
    logic                    w_sign2;
    logic                    w_calc_last;
    logic [DATA_WIDTH-1:0]   w_abs1;
    logic [DATA_WIDTH-1:0]   w_abs2;
    logic [DATA_WIDTH-1:0]   w_fixed;
    logic [DATA_WIDTH-1:0]   w_mplier_shr;

    assign w_op_in      = op_e'(i_op);
    assign w_sign1      = rs1_signed(w_op_in) & i_multiplicand[DATA_WIDTH-1];
    assign w_sign2      = rs2_signed(w_op_in) & i_multiplier[DATA_WIDTH-1];
    assign w_mplier_shr = r_mplier >> 1;

    // |-2^(W-1)| = 2^(W-1) still fits unsigned in W bits, so the low half is the exact magnitude.
    mul_sign_fix #(.DATA_WIDTH(DATA_WIDTH)) u_abs_rs1 (
        .i_acc    ({{DATA_WIDTH{1'b0}}, i_multiplicand}),
        .i_neg    (w_sign1),
        .i_op     (OP_MUL),
        .o_result (w_abs1)
    );

    mul_sign_fix #(.DATA_WIDTH(DATA_WIDTH)) u_abs_rs2 (
        .i_acc    ({{DATA_WIDTH{1'b0}}, i_multiplier}),
        .i_neg    (w_sign2),
        .i_op     (OP_MUL),
        .o_result (w_abs2)
    );

    mul_sign_fix #(.DATA_WIDTH(DATA_WIDTH)) u_res_fix (
        .i_acc    (r_acc),
        .i_neg    (r_neg),
        .i_op     (r_op),
        .o_result (w_fixed)
    );

`ifdef MUL_EARLY_OUT_EN
    assign w_calc_last = (r_cnt == CW'(DATA_WIDTH-1)) || (w_mplier_shr == '0);
`else
    assign w_calc_last = (r_cnt == CW'(DATA_WIDTH-1));
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (i_in_valid)  w_state_nxt = ST_CALC;
            ST_CALC: if (w_calc_last) w_state_nxt = ST_SIGN;
            ST_SIGN:                  w_state_nxt = ST_DONE;
            ST_DONE: if (i_out_ready) w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_op     <= OP_MUL;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_in_valid) begin
                        r_op     <= w_op_in;
                        r_mcand  <= {{DATA_WIDTH{1'b0}}, w_abs1};
                        r_mplier <= w_abs2;
                        r_neg    <= w_sign1 ^ w_sign2;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                ST_CALC: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_shr;
                    r_cnt    <= r_cnt + CW'(1);
                end
                ST_SIGN: r_result <= w_fixed;
                default: ;
            endcase
        end
    end

    assign o_in_ready  = (r_state == ST_IDLE);
    assign o_out_valid = (r_state == ST_DONE);
    assign o_busy      = (r_state != ST_IDLE);
    assign o_result    = r_result;

endmodule
